// File: rtl/poly_ctrl.sv
// Moore sequencer for the Horner-form polynomial datapath (A*x^2+B*x+C or B*x+C).
// Latency: 7 cycles per quadratic run, 5 per linear, IDLE included; start is dropped while busy.
module poly_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       lx,
    output logic       ls,
    output logic       lh,
    output logic       h,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_Q1   = 3'd2,
        S_Q2   = 3'd3,
        S_Q3   = 3'd4,
        S_L1   = 3'd5,
        S_FIN  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    typedef struct packed {
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       lx;
        logic       ls;
        logic       lh;
        logic       h;
        logic       busy;
        logic       done;
    } ctrl_t;

    state_t state_q, state_d;
    logic   mode_q, mode_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // mode is captured only on the IDLE->LOAD transition and held for the run
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    mode_d  = mode;
                end
            end
            S_LOAD:  state_d = mode_q ? S_L1 : S_Q1;
            S_Q1:    state_d = S_Q2;
            S_Q2:    state_d = S_Q3;
            S_Q3:    state_d = S_FIN;
            S_L1:    state_d = S_FIN;
            S_FIN:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_IDLE: ctrl = '0;
            S_LOAD: begin
                ctrl.lx   = 1'b1;
                ctrl.ls   = 1'b1;
                ctrl.m2   = 2'b11;
                ctrl.busy = 1'b1;
            end
            S_Q1: begin
                ctrl.m0   = 2'b01;
                ctrl.m1   = 2'b00;
                ctrl.h    = 1'b1;
                ctrl.lh   = 1'b1;
                ctrl.busy = 1'b1;
            end
            S_Q2: begin
                ctrl.m0   = 2'b10;
                ctrl.m1   = 2'b01;
                ctrl.h    = 1'b0;
                ctrl.lh   = 1'b1;
                ctrl.busy = 1'b1;
            end
            S_Q3: begin
                ctrl.m0   = 2'b00;
                ctrl.m1   = 2'b01;
                ctrl.h    = 1'b1;
                ctrl.lh   = 1'b1;
                ctrl.busy = 1'b1;
            end
            S_L1: begin
                ctrl.m0   = 2'b10;
                ctrl.m1   = 2'b00;
                ctrl.h    = 1'b1;
                ctrl.lh   = 1'b1;
                ctrl.busy = 1'b1;
            end
            S_FIN: begin
                ctrl.m0   = 2'b11;
                ctrl.m1   = 2'b01;
                ctrl.h    = 1'b0;
                ctrl.ls   = 1'b1;
                ctrl.m2   = 2'b00;
                ctrl.busy = 1'b1;
            end
            S_DONE: begin
                ctrl.done = 1'b1;
                ctrl.busy = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign m0   = ctrl.m0;
    assign m1   = ctrl.m1;
    assign m2   = ctrl.m2;
    assign lx   = ctrl.lx;
    assign ls   = ctrl.ls;
    assign lh   = ctrl.lh;
    assign h    = ctrl.h;
    assign busy = ctrl.busy;
    assign done = ctrl.done;

endmodule

// File: tb/tb_poly_ctrl.sv
// Directed bench: poly_ctrl driving a bit-accurate model of the polynomial datapath.
module tb_poly_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] m0, m1, m2;
    logic       lx, ls, lh, h, busy, done;

    logic [15:0] a_v = '0, b_v = '0, c_v = '0, xis = '0;
    logic [15:0] x_r, s_r, h_r;
    logic [15:0] op0, op1, alu, wd;
    logic [31:0] prod;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int done_t[$];
    logic [15:0] done_s[$];

    // Control vectors {m0,m1,m2,lx,ls,lh,h,busy,done} per state
    localparam logic [11:0] V_IDLE = 12'b00_00_00_0_0_0_0_0_0;
    localparam logic [11:0] V_LOAD = 12'b00_00_11_1_1_0_0_1_0;
    localparam logic [11:0] V_Q1   = 12'b01_00_00_0_0_1_1_1_0;
    localparam logic [11:0] V_Q2   = 12'b10_01_00_0_0_1_0_1_0;
    localparam logic [11:0] V_Q3   = 12'b00_01_00_0_0_1_1_1_0;
    localparam logic [11:0] V_L1   = 12'b10_00_00_0_0_1_1_1_0;
    localparam logic [11:0] V_FIN  = 12'b11_01_00_0_1_0_0_1_0;
    localparam logic [11:0] V_DONE = 12'b00_00_00_0_0_0_0_1_1;

    poly_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .m0    (m0),
        .m1    (m1),
        .m2    (m2),
        .lx    (lx),
        .ls    (ls),
        .lh    (lh),
        .h     (h),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        op0 = '0;
        op1 = '0;
        case (m0)
            2'b00: op0 = x_r;
            2'b01: op0 = a_v;
            2'b10: op0 = b_v;
            default: op0 = c_v;
        endcase
        case (m1)
            2'b00: op1 = x_r;
            2'b01: op1 = h_r;
            2'b10: op1 = s_r;
            default: op1 = 16'd0;
        endcase
        prod = {16'd0, op0} * {16'd0, op1};
        alu  = h ? prod[15:0] : op0 + op1;
        wd   = (m2 == 2'b11) ? 16'd0 : alu;
    end

    always @(posedge clk) begin
        if (rst) begin
            x_r <= '0;
            s_r <= '0;
            h_r <= '0;
        end else begin
            if (lx) x_r <= xis;
            if (ls) s_r <= wd;
            if (lh) h_r <= wd;
        end
    end

    always @(negedge clk) begin
        if (!rst && done) begin
            done_t.push_back(cyc);
            done_s.push_back(s_r);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cv();
        return {20'd0, m0, m1, m2, lx, ls, lh, h, busy, done};
    endfunction

    // One isolated run from IDLE with a single-cycle start; walks the state table cycle by cycle
    task automatic run_one(input string tag, input logic md, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] c, input logic [15:0] x,
                           input logic [15:0] exp_s);
        logic [11:0] seq[7];
        int len, n_lh, n_ls, n_busy, first_done;
        n_lh = 0; n_ls = 0; n_busy = 0; first_done = -1;
        if (!md) begin
            seq = '{V_LOAD, V_Q1, V_Q2, V_Q3, V_FIN, V_DONE, V_IDLE};
            len = 7;
        end else begin
            seq = '{V_LOAD, V_L1, V_FIN, V_DONE, V_IDLE, V_IDLE, V_IDLE};
            len = 5;
        end
        a_v = a; b_v = b; c_v = c; xis = x;
        mode = md; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_ctrl_cyc%0d", tag, i + 1), cv(), {20'd0, seq[i]});
            if (lh) n_lh++;
            if (ls) n_ls++;
            if (busy) n_busy++;
            if (done && first_done < 0) first_done = i + 1;
            if (i == len - 2) check({tag, "_s"}, {16'd0, s_r}, {16'd0, exp_s});
            if (i < len - 1) tick();
        end
        check({tag, "_latency"}, 32'(first_done), md ? 32'd4 : 32'd6);
        check({tag, "_busy_cycles"}, 32'(n_busy), md ? 32'd4 : 32'd6);
        check({tag, "_lh_cycles"}, 32'(n_lh), md ? 32'd1 : 32'd3);
        check({tag, "_ls_cycles"}, 32'(n_ls), 32'd2);
    endtask

    // Holds start high until two done pulses are seen (bounded), then checks spacing and result
    task automatic run_b2b(input string tag, input logic md, input logic [15:0] exp_s,
                           input int exp_period, input logic toggle_mode);
        int base;
        base = done_t.size();
        a_v = 16'd2; b_v = 16'd3; c_v = 16'd4; xis = 16'd5;
        mode = md; start = 1'b1;
        tick();
        tick();
        if (toggle_mode) mode = ~md;
        tick();
        tick();
        if (toggle_mode) mode = md;
        for (int i = 0; i < 40 && done_t.size() < base + 2; i++) tick();
        start = 1'b0;
        check({tag, "_two_dones"}, 32'(done_t.size() >= base + 2), 32'd1);
        if (done_t.size() >= base + 2) begin
            check({tag, "_period"}, 32'(done_t[base + 1] - done_t[base]), 32'(exp_period));
            check({tag, "_s1"}, {16'd0, done_s[base]}, {16'd0, exp_s});
            check({tag, "_s2"}, {16'd0, done_s[base + 1]}, {16'd0, exp_s});
        end
        repeat (10) tick();
        check({tag, "_no_extra_done"}, 32'(done_t.size()), 32'(base + 2));
    endtask

    initial begin
        logic [31:0] acc;
        int base;

        // Reset with start asserted, then release with start low
        rst = 1'b1; start = 1'b1; mode = 1'b0;
        tick();
        tick();
        check("rst_outputs", cv(), 32'd0);
        rst = 1'b0; start = 1'b0;
        acc = '0;
        repeat (12) begin
            tick();
            acc |= cv();
        end
        check("idle_hold", acc, 32'd0);

        run_one("quad", 1'b0, 16'd2, 16'd3, 16'd4, 16'd5, 16'd69);
        run_one("lin", 1'b1, 16'd0, 16'd3, 16'd4, 16'd5, 16'd19);
        run_one("wrap", 1'b0, 16'h0100, 16'h0000, 16'h0001, 16'h0100, 16'h0001);

        // Start and mode change while busy are ignored
        base = done_t.size();
        a_v = 16'd1; b_v = 16'd1; c_v = 16'd1; xis = 16'd2;
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("busy_q2", cv(), {20'd0, V_Q2});
        start = 1'b1; mode = 1'b1;
        xis = 16'd9;
        tick();
        check("busy_q3", cv(), {20'd0, V_Q3});
        start = 1'b0; mode = 1'b0;
        tick();
        check("busy_fin", cv(), {20'd0, V_FIN});
        tick();
        check("busy_done", cv(), {20'd0, V_DONE});
        check("busy_s", {16'd0, s_r}, 32'd7);
        tick();
        check("busy_idle", cv(), {20'd0, V_IDLE});
        repeat (6) tick();
        check("busy_stays_idle", cv(), 32'd0);
        check("busy_one_done", 32'(done_t.size() - base), 32'd1);

        // Reset in Q3 aborts without a done pulse
        base = done_t.size();
        a_v = 16'd2; b_v = 16'd3; c_v = 16'd4; xis = 16'd5;
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_in_q3", cv(), {20'd0, V_Q3});
        rst = 1'b1;
        tick();
        check("midrst_outputs", cv(), 32'd0);
        check("midrst_s_cleared", {16'd0, s_r}, 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        check("midrst_no_done", 32'(done_t.size()), 32'(base));
        check("midrst_idle", cv(), 32'd0);

        run_b2b("b2b_quad", 1'b0, 16'd69, 7, 1'b1);
        run_b2b("b2b_lin", 1'b1, 16'd19, 5, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
